// File: rtl/ahbl_if.sv
// ahbl_if: AHB-Lite address/control/data bundle shared by masters and slaves
interface ahbl_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastrlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hmastrlock, hwdata,
    input  hrdata, hready, hresp
  );
  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastrlock, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahbl_arb2.sv
// ahbl_arb2: two-master AHB-Lite arbiter with per-port pending address slots
module ahbl_arb2 #(
  parameter bit RR = 1'b1
) (
  input logic   hclk,
  input logic   hreset,
  ahbl_if.slave  s0,
  ahbl_if.slave  s1,
  ahbl_if.master m
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} st_t;
  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastrlock;
  } ac_t;
  st_t        st, nst;
  ac_t        lv [2];
  ac_t        pend [2];
  ac_t        fw;
  logic [1:0] pend_v, rq, rn, sh, shr, cap, clr;
  logic       eo_v, eo, gi, gn, arb, xfer, last, last_n, dp_v, dp_own;
  assign lv[0] = {s0.haddr, s0.htrans, s0.hwrite, s0.hsize, s0.hburst, s0.hprot, s0.hmastrlock};
  assign lv[1] = {s1.haddr, s1.htrans, s1.hwrite, s1.hsize, s1.hburst, s1.hprot, s1.hmastrlock};
  // Effective owner (granted combinationally out of IDLE) and the transfer it presents
  always_comb begin
    rq = pend_v | {lv[1].htrans[1], lv[0].htrans[1]};
    gi = &rq ? (RR ? ~last : 1'b0) : rq[1];
    eo_v = st != IDLE || |rq;
    eo = st == IDLE ? gi : st == OWN1;
    fw = hreset || !eo_v ? '0 : pend_v[eo] ? pend[eo] : lv[eo];
    xfer = m.hready && fw.htrans[1];
    arb = m.hready && !fw.htrans[0] && !fw.hmastrlock;
  end
  // Per-port handshake, pending capture/release and next owner
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sh[i] = hreset || (dp_v && dp_own == 1'(i) ? m.hready : !pend_v[i]);
      shr[i] = !hreset && dp_v && dp_own == 1'(i) && m.hresp;
      cap[i] = sh[i] && lv[i].htrans[1] && !(eo_v && eo == 1'(i) && !pend_v[i] && m.hready);
      clr[i] = eo_v && eo == 1'(i) && pend_v[i] && m.hready;
    end
    rn = (pend_v & ~clr) | {lv[1].htrans[1], lv[0].htrans[1]};
    last_n = xfer ? eo : last;
    gn = &rn ? (RR ? ~last_n : 1'b0) : rn[1];
    nst = !arb ? (!eo_v ? IDLE : eo ? OWN1 : OWN0) : !(|rn) ? IDLE : gn ? OWN1 : OWN0;
  end
  // Owner state, last-served pointer and data-phase owner
  always_ff @(posedge hclk)
    if (hreset) begin
      st <= IDLE;
      last <= 1'b1;
      dp_v <= 1'b0;
      dp_own <= 1'b0;
    end else begin
      st <= nst;
      last <= last_n;
      if (m.hready) begin
        dp_v <= fw.htrans[1];
        dp_own <= eo;
      end
    end
  // Pending address slots
  always_ff @(posedge hclk)
    for (int i = 0; i < 2; i++)
      if (hreset) pend_v[i] <= 1'b0;
      else if (cap[i]) begin
        pend_v[i] <= 1'b1;
        pend[i] <= lv[i];
      end else if (clr[i]) pend_v[i] <= 1'b0;
  assign m.haddr = fw.haddr;
  assign m.htrans = fw.htrans;
  assign m.hwrite = fw.hwrite;
  assign m.hsize = fw.hsize;
  assign m.hburst = fw.hburst;
  assign m.hprot = fw.hprot;
  assign m.hmastrlock = fw.hmastrlock;
  assign m.hwdata = dp_own ? s1.hwdata : s0.hwdata;
  assign s0.hrdata = m.hrdata;
  assign s1.hrdata = m.hrdata;
  assign s0.hready = sh[0];
  assign s1.hready = sh[1];
  assign s0.hresp = shr[0];
  assign s1.hresp = shr[1];
endmodule

// File: tb/tb_ahbl_arb2.sv
// tb_ahbl_arb2: directed checks of ahbl_arb2 arbitration, buffering and reset
module tb_ahbl_arb2;
  logic hclk = 1'b0;
  logic hreset;
  int   errors = 0;
  int   checks = 0;
  ahbl_if s0_if ();
  ahbl_if s1_if ();
  ahbl_if m_if ();
  ahbl_arb2 #(.RR(1'b1)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .s0    (s0_if.slave),
    .s1    (s1_if.slave),
    .m     (m_if.master)
  );
  always #5 hclk = ~hclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drv(input int p, input logic [1:0] t, input logic [31:0] a, input logic w,
                     input logic [2:0] b, input logic l);
    if (p == 0) begin
      s0_if.htrans = t; s0_if.haddr = a; s0_if.hwrite = w; s0_if.hburst = b;
      s0_if.hmastrlock = l; s0_if.hsize = 3'd2; s0_if.hprot = 4'h3;
    end else begin
      s1_if.htrans = t; s1_if.haddr = a; s1_if.hwrite = w; s1_if.hburst = b;
      s1_if.hmastrlock = l; s1_if.hsize = 3'd2; s1_if.hprot = 4'h3;
    end
  endtask
  task automatic cyc;
    @(posedge hclk);
    #1;
  endtask
  task automatic idle;
    drv(0, 2'd0, 0, 0, 0, 0);
    drv(1, 2'd0, 0, 0, 0, 0);
  endtask
  initial begin
    hreset = 1'b1;
    idle();
    drv(0, 2'd2, 32'hdead0000, 1, 0, 0);
    s0_if.hwdata = 0; s1_if.hwdata = 0;
    m_if.hready = 1'b1; m_if.hresp = 1'b1; m_if.hrdata = 0;
    cyc(); cyc();
    #3;
    chk("rst_htrans", m_if.htrans, 0);
    chk("rst_haddr", m_if.haddr, 0);
    chk("rst_s0rdy", s0_if.hready, 1);
    chk("rst_s1rdy", s1_if.hready, 1);
    chk("rst_s0resp", s0_if.hresp, 0);
    chk("rst_s1resp", s1_if.hresp, 0);
    cyc();
    hreset = 1'b0; m_if.hresp = 1'b0; idle();
    #3;
    chk("post_htrans", m_if.htrans, 0);
    chk("post_s0rdy", s0_if.hready, 1);
    cyc();
    drv(0, 2'd2, 32'h10, 0, 0, 0); drv(1, 2'd2, 32'h20, 0, 0, 0);
    #3;
    chk("tie0_haddr", m_if.haddr, 32'h10);
    chk("tie0_htrans", m_if.htrans, 2);
    chk("tie0_s1rdy", s1_if.hready, 1);
    cyc();
    drv(0, 2'd2, 32'h14, 0, 0, 0); drv(1, 2'd0, 0, 0, 0, 0); m_if.hrdata = 32'h1111;
    #3;
    chk("tie1_haddr", m_if.haddr, 32'h20);
    chk("tie1_htrans", m_if.htrans, 2);
    chk("tie1_s1rdy", s1_if.hready, 0);
    chk("tie1_s0rdy", s0_if.hready, 1);
    chk("tie1_s0rdata", s0_if.hrdata, 32'h1111);
    cyc();
    idle(); m_if.hrdata = 32'h2222;
    #3;
    chk("tie2_haddr", m_if.haddr, 32'h14);
    chk("tie2_s1rdy", s1_if.hready, 1);
    chk("tie2_s0rdy", s0_if.hready, 0);
    chk("tie2_s1rdata", s1_if.hrdata, 32'h2222);
    cyc();
    #3;
    chk("tie3_htrans", m_if.htrans, 0);
    chk("tie3_s0rdy", s0_if.hready, 1);
    cyc();
    drv(0, 2'd2, 32'h1000, 1, 0, 0);
    #3;
    chk("one_haddr", m_if.haddr, 32'h1000);
    chk("one_hwrite", m_if.hwrite, 1);
    chk("one_s1rdy0", s1_if.hready, 1);
    cyc();
    idle(); s0_if.hwdata = 32'ha5a50001; s1_if.hwdata = 32'h5a5a0002;
    #3;
    chk("one_hwdata", m_if.hwdata, 32'ha5a50001);
    chk("one_htrans", m_if.htrans, 0);
    chk("one_s1rdy1", s1_if.hready, 1);
    cyc();
    drv(0, 2'd2, 32'h100, 1, 3'd3, 0);
    #3;
    chk("b0_haddr", m_if.haddr, 32'h100);
    chk("b0_hburst", m_if.hburst, 3);
    cyc();
    drv(0, 2'd3, 32'h104, 1, 3'd3, 0); drv(1, 2'd2, 32'h200, 0, 0, 0);
    #3;
    chk("b1_haddr", m_if.haddr, 32'h104);
    chk("b1_htrans", m_if.htrans, 3);
    chk("b1_s1rdy", s1_if.hready, 1);
    cyc();
    drv(0, 2'd3, 32'h108, 1, 3'd3, 0); drv(1, 2'd0, 0, 0, 0, 0);
    #3;
    chk("b2_haddr", m_if.haddr, 32'h108);
    chk("b2_s1rdy", s1_if.hready, 0);
    cyc();
    drv(0, 2'd3, 32'h10c, 1, 3'd3, 0);
    #3;
    chk("b3_haddr", m_if.haddr, 32'h10c);
    chk("b3_s1rdy", s1_if.hready, 0);
    cyc();
    idle();
    #3;
    chk("b4_htrans", m_if.htrans, 0);
    chk("b4_s1rdy", s1_if.hready, 0);
    cyc();
    #3;
    chk("b5_haddr", m_if.haddr, 32'h200);
    chk("b5_htrans", m_if.htrans, 2);
    chk("b5_s1rdy", s1_if.hready, 0);
    cyc();
    #3;
    chk("b6_s1rdy", s1_if.hready, 1);
    chk("b6_htrans", m_if.htrans, 0);
    cyc();
    drv(1, 2'd2, 32'h300, 0, 0, 0);
    #3;
    chk("e0_haddr", m_if.haddr, 32'h300);
    cyc();
    drv(1, 2'd0, 0, 0, 0, 0); drv(0, 2'd2, 32'h400, 0, 0, 0); m_if.hready = 1'b0;
    #3;
    chk("e1_s1rdy", s1_if.hready, 0);
    chk("e1_s0rdy", s0_if.hready, 1);
    chk("e1_htrans", m_if.htrans, 0);
    cyc();
    drv(0, 2'd0, 0, 0, 0, 0);
    #3;
    chk("e2_s0rdy", s0_if.hready, 0);
    chk("e2_s1rdy", s1_if.hready, 0);
    cyc();
    m_if.hresp = 1'b1;
    #3;
    chk("e3_s1resp", s1_if.hresp, 1);
    chk("e3_s1rdy", s1_if.hready, 0);
    chk("e3_s0resp", s0_if.hresp, 0);
    cyc();
    m_if.hready = 1'b1;
    #3;
    chk("e4_s1resp", s1_if.hresp, 1);
    chk("e4_s1rdy", s1_if.hready, 1);
    chk("e4_s0resp", s0_if.hresp, 0);
    chk("e4_s0rdy", s0_if.hready, 0);
    chk("e4_htrans", m_if.htrans, 0);
    cyc();
    m_if.hresp = 1'b0;
    #3;
    chk("e5_haddr", m_if.haddr, 32'h400);
    chk("e5_htrans", m_if.htrans, 2);
    chk("e5_s0rdy", s0_if.hready, 0);
    chk("e5_s1resp", s1_if.hresp, 0);
    cyc();
    #3;
    chk("e6_s0rdy", s0_if.hready, 1);
    cyc();
    drv(1, 2'd2, 32'h500, 0, 0, 1);
    #3;
    chk("l0_haddr", m_if.haddr, 32'h500);
    chk("l0_lock", m_if.hmastrlock, 1);
    cyc();
    drv(1, 2'd2, 32'h504, 0, 0, 1); drv(0, 2'd2, 32'h600, 0, 0, 0);
    #3;
    chk("l1_haddr", m_if.haddr, 32'h504);
    chk("l1_s0rdy", s0_if.hready, 1);
    cyc();
    idle();
    #3;
    chk("l2_htrans", m_if.htrans, 0);
    chk("l2_s0rdy", s0_if.hready, 0);
    cyc();
    #3;
    chk("l3_haddr", m_if.haddr, 32'h600);
    chk("l3_lock", m_if.hmastrlock, 0);
    cyc();
    #3;
    chk("l4_htrans", m_if.htrans, 0);
    cyc();
    drv(0, 2'd2, 32'h700, 0, 3'd3, 0);
    #3;
    chk("r0_haddr", m_if.haddr, 32'h700);
    cyc();
    drv(0, 2'd3, 32'h704, 0, 3'd3, 0); drv(1, 2'd2, 32'h20, 0, 0, 0);
    #3;
    chk("r1_haddr", m_if.haddr, 32'h704);
    chk("r1_s1rdy", s1_if.hready, 1);
    cyc();
    idle(); hreset = 1'b1;
    #3;
    chk("r2_htrans", m_if.htrans, 0);
    chk("r2_s1rdy", s1_if.hready, 1);
    cyc();
    hreset = 1'b0;
    #3;
    chk("r3_htrans", m_if.htrans, 0);
    chk("r3_haddr", m_if.haddr, 0);
    chk("r3_s1rdy", s1_if.hready, 1);
    cyc();
    #3;
    chk("r4_htrans", m_if.htrans, 0);
    chk("r4_haddr", m_if.haddr, 0);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
